divider_seq: RTL and testbench

DIVIDER_SEQ -- requirements
Module: divider_seq

---
 rtl/divider_seq.sv | 123 ++++++++++++
 tb/tb_divider_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/divider_seq.sv
// Sequential restoring divider: one quotient bit per cycle, fixed WIDTH-cycle run.
// Optional signed support is enabled by defining DIVIDER_SEQ_SIGNED_EN.
`timescale 1ns/1ps
module divider_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             signed_op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   prem;
    logic             dbz, neg_q, neg_r;
    logic             accept, last;
    logic             a_neg, b_neg;
    logic [WIDTH+1:0] shifted, diff;
    logic             qbit;
    logic [WIDTH:0]   prem_nxt;
    logic [WIDTH-1:0] dq_nxt;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // A zero divisor always reports all ones, whatever the operand signs.
    function automatic logic [WIDTH-1:0] fix_quot(input logic [WIDTH-1:0] mag,
                                                  input logic neg, input logic zero);
        if (zero)
            return '1;
        return cond_neg(mag, neg);
    endfunction

`ifdef DIVIDER_SEQ_SIGNED_EN
    assign a_neg = signed_op & dividend[WIDTH-1];
    assign b_neg = signed_op & divisor[WIDTH-1];
`else
    logic sign_unused;
    assign a_neg       = 1'b0;
    assign b_neg       = 1'b0;
    assign sign_unused = signed_op;
`endif

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST_CNT) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = (state == IDLE) && start;
    assign last   = (state == RUN) && (cnt == LAST_CNT);

    // Dividend bits leave dq at the top while quotient bits enter at the bottom.
    assign shifted  = {prem, dq[WIDTH-1]};
    assign diff     = shifted - {2'b00, dvs};
    assign qbit     = ~diff[WIDTH+1];
    assign prem_nxt = qbit ? diff[WIDTH:0] : shifted[WIDTH:0];
    assign dq_nxt   = {dq[WIDTH-2:0], qbit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept)
                cnt <= '0;
            else if (state == RUN)
                cnt <= cnt + 1'b1;
            if (last) begin
                quotient    <= fix_quot(dq_nxt, neg_q, dbz);
                remainder   <= cond_neg(prem_nxt[WIDTH-1:0], neg_r);
                div_by_zero <= dbz;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            dq    <= cond_neg(dividend, a_neg);
            dvs   <= cond_neg(divisor, b_neg);
            prem  <= '0;
            dbz   <= (divisor == '0);
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
        end else if (state == RUN) begin
            dq   <= dq_nxt;
            prem <= prem_nxt;
        end
    end

endmodule

// File: tb/tb_divider_seq.sv
// Randomized self-checking bench for divider_seq against an arithmetic reference model.
`timescale 1ns/1ps
module tb_divider_seq;
    localparam int WIDTH = 32;
`ifdef DIVIDER_SEQ_SIGNED_EN
    localparam bit SIGNED_MODE = 1'b1;
`else
    localparam bit SIGNED_MODE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, start, signed_op;
    logic             busy, done, div_by_zero;
    logic [WIDTH-1:0] dividend, divisor, quotient, remainder;
    int               checks = 0;
    int               errors = 0;

    divider_seq #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .signed_op  (signed_op),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Truncating division; zero divisor gives all-ones quotient and the dividend back.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [31:0] q, output logic [31:0] r, output logic z);
        z = (b == 0);
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (SIGNED_MODE && s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic pick(output logic [31:0] a, output logic [31:0] b);
        a = $urandom;
        case ($urandom_range(0, 7))
            0:       b = 0;
            1:       b = $urandom_range(1, 15);
            2:       b = a >> $urandom_range(0, 31);
            3:       b = a;
            default: b = $urandom;
        endcase
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] eq, input logic [31:0] er,
                          input logic ez);
        int n;
        wait_idle();
        dividend  = a;
        divisor   = b;
        signed_op = s;
        start     = 1'b1;
        tick();
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(WIDTH));
        check({tag, "_q"}, 64'(quotient), 64'(eq));
        check({tag, "_r"}, 64'(remainder), 64'(er));
        check({tag, "_z"}, 64'(div_by_zero), 64'(ez));
    endtask

    initial begin
        logic [31:0] a, b, eq, er, qs, rs;
        logic        ez, s;
        int          pulses, cyc;

        rst = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_q", 64'(quotient), 64'd0);
        check("rst_r", 64'(remainder), 64'd0);
        check("rst_z", 64'(div_by_zero), 64'd0);
        rst = 1'b0;
        tick();

        run_op("d100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        tick();
        check("done_width", 64'(done), 64'd0);
        check("idle_after_done", 64'(busy), 64'd0);

        // Extra starts in RUN (cycle 5) and DONE (cycle 33) must be ignored.
        wait_idle();
        dividend = 32'd1000; divisor = 32'd9; signed_op = 1'b0; start = 1'b1;
        tick();
        pulses = 0; qs = '0; rs = '0;
        for (int i = 1; i <= 40; i++) begin
            start    = (i == 5) || (i == 33);
            dividend = $urandom;
            divisor  = $urandom;
            tick();
            if (done) begin
                pulses++;
                qs = quotient;
                rs = remainder;
            end
        end
        start = 1'b0;
        check("ign_pulses", 64'(pulses), 64'd1);
        check("ign_q", 64'(qs), 64'd111);
        check("ign_r", 64'(rs), 64'd1);
        check("ign_idle", 64'(busy), 64'd0);

        run_op("dbz", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);

        // Asynchronous reset in the middle of a run.
        wait_idle();
        dividend = 32'd500; divisor = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_q", 64'(quotient), 64'd0);
        check("arst_r", 64'(remainder), 64'd0);
        check("arst_z", 64'(div_by_zero), 64'd0);
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) pulses++;
        end
        check("arst_no_done", 64'(pulses), 64'd0);
        run_op("d9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);

`ifdef DIVIDER_SEQ_SIGNED_EN
        run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
        run_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
        run_op("s_dbz", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
`else
        run_op("u_sop", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0);
`endif

        for (int i = 0; i < 200; i++) begin
            pick(a, b);
            s = 1'($urandom_range(0, 1));
            ref_div(a, b, s, eq, er, ez);
            run_op("rnd", a, b, s, eq, er, ez);
        end

        // Back-to-back unsigned stream with start held high.
        wait_idle();
        pick(a, b);
        dividend = a; divisor = b; signed_op = 1'b0; start = 1'b1;
        tick();
        for (int k = 0; k < 1500; k++) begin
            tick();
            cyc = 1;
            while (!done && cyc < 100) begin
                tick();
                cyc++;
            end
            if (k == 0)
                check("b2b_first_lat", 64'(cyc), 64'(WIDTH));
            else
                check("b2b_spacing", 64'(cyc), 64'(WIDTH + 2));
            ref_div(a, b, 1'b0, eq, er, ez);
            check("b2b_q", 64'(quotient), 64'(eq));
            check("b2b_r", 64'(remainder), 64'(er));
            check("b2b_z", 64'(div_by_zero), 64'(ez));
            pick(a, b);
            dividend = a;
            divisor  = b;
        end
        start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
